// File: rtl/if_id_stage_skid.sv
// IF/ID register with valid bit, one-entry skid and post-reset warm-up; 1-cycle latency.
// Backpressure: in_ready drops while the skid entry is occupied; stall holds the stage.
module if_id_stage_skid #(
   parameter int unsigned          XLEN      = 32,
   parameter int unsigned          ILEN      = 32,
   parameter logic [ILEN-1:0]      NOP_INSTR = 32'h0000_0013,
   parameter int unsigned          WARMUP    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            stall,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc_in,
   input  logic [ILEN-1:0] instr_in,
   output logic            out_valid,
   output logic [XLEN-1:0] pc_out,
   output logic [ILEN-1:0] instr_out,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [24:0]     imm,
   output logic            skid_full
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } entry_t;

   localparam logic [2:0] WARMUP_INIT = 3'(WARMUP);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            skid_full_q, skid_full_d;
   entry_t          skid_q, skid_d;
   logic [2:0]      warm_q, warm_d;
   logic            accept;

   assign in_ready = !skid_full_q;
   assign accept   = in_valid & in_ready;

   always_comb begin
      pc_d        = pc_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      skid_full_d = skid_full_q;
      skid_d      = skid_q;
      warm_d      = warm_q;

      if (flush) begin
         pc_d        = '0;
         instr_d     = NOP_INSTR;
         valid_d     = 1'b0;
         skid_full_d = 1'b0;
      end else if (stall) begin
         // Memory still returns data during a stall; park it unless warming up.
         if (accept && (warm_q == 3'd0)) begin
            skid_d.pc    = pc_in;
            skid_d.instr = instr_in;
            skid_full_d  = 1'b1;
         end
      end else if (skid_full_q) begin
         pc_d        = skid_q.pc;
         instr_d     = skid_q.instr;
         valid_d     = 1'b1;
         skid_full_d = 1'b0;
      end else if (warm_q != 3'd0) begin
         warm_d  = warm_q - 3'd1;
         pc_d    = pc_in;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (accept) begin
         pc_d    = pc_in;
         instr_d = instr_in;
         valid_d = 1'b1;
      end else begin
         pc_d    = pc_in;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q         <= '0;
         instr_q      <= NOP_INSTR;
         valid_q      <= 1'b0;
         skid_full_q  <= 1'b0;
         skid_q.pc    <= '0;
         skid_q.instr <= NOP_INSTR;
         warm_q       <= WARMUP_INIT;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         skid_full_q <= skid_full_d;
         skid_q      <= skid_d;
         warm_q      <= warm_d;
      end
   end

   assign out_valid = valid_q;
   assign pc_out    = pc_q;
   assign instr_out = instr_q;
   assign skid_full = skid_full_q;

   // Pure slices: a bubble decodes as addi x0,x0,0.
   assign opcode = instr_q[6:0];
   assign rd     = instr_q[11:7];
   assign funct3 = instr_q[14:12];
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];
   assign funct7 = instr_q[31:25];
   assign imm    = instr_q[31:7];

endmodule

// File: tb/tb_if_id_stage_skid.sv
// Bench for if_id_stage_skid: directed vector table, async-reset sequence, random run vs model.
module tb_if_id_stage_skid;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush, stall, in_valid, in_ready;
   logic [31:0] pc_in, instr_in;
   logic        out_valid, skid_full;
   logic [31:0] pc_out, instr_out;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [24:0] imm;

   if_id_stage_skid #(.XLEN(32), .ILEN(32), .NOP_INSTR(32'h0000_0013), .WARMUP(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .instr_in(instr_in),
      .out_valid(out_valid), .pc_out(pc_out), .instr_out(instr_out),
      .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
      .rd(rd), .imm(imm), .skid_full(skid_full)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: stage register plus a skid queue holding at most one entry.
   typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
   ent_t        m_skid[$];
   logic [31:0] m_pc, m_ins;
   logic        m_v;
   int          m_warm;
   logic        m_rdy;
   logic        rdy_obs;

   task automatic model_reset();
      m_skid.delete();
      m_pc = 0; m_ins = NOP; m_v = 0; m_warm = 1;
   endtask

   task automatic model_step(input logic f, s, v, input logic [31:0] p, i);
      ent_t e;
      logic acc;
      m_rdy = (m_skid.size() == 0);
      acc   = v && m_rdy;
      if (f) begin
         m_pc = 0; m_ins = NOP; m_v = 0; m_skid.delete();
      end else if (s) begin
         if (acc && m_warm == 0) begin
            e.pc = p; e.ins = i; m_skid.push_back(e);
         end
      end else if (m_skid.size() != 0) begin
         e = m_skid.pop_front();
         m_pc = e.pc; m_ins = e.ins; m_v = 1;
      end else if (m_warm > 0) begin
         m_warm--; m_pc = p; m_ins = NOP; m_v = 0;
      end else if (acc) begin
         m_pc = p; m_ins = i; m_v = 1;
      end else begin
         m_pc = p; m_ins = NOP; m_v = 0;
      end
   endtask

   task automatic drive(input logic f, s, v, input logic [31:0] p, i);
      flush = f; stall = s; in_valid = v; pc_in = p; instr_in = i;
      #1;
      rdy_obs = in_ready;
      model_step(f, s, v, p, i);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic f, s, v;
      logic [31:0] pc, ins;
      logic rdy, ov;
      logic [31:0] opc, oins;
      logic sk;
   } vec_t;

   function automatic vec_t mk(logic f, s, v, logic [31:0] pc, ins,
                               logic rdy, ov, logic [31:0] opc, oins, logic sk);
      vec_t t;
      t.f = f; t.s = s; t.v = v; t.pc = pc; t.ins = ins;
      t.rdy = rdy; t.ov = ov; t.opc = opc; t.oins = oins; t.sk = sk;
      return t;
   endfunction

   vec_t tbl[14];

   initial begin
      logic [31:0] e;
      tbl[0]  = mk(0,0,1,32'h00,32'hDEADBEEF, 1,0,32'h00,NOP,0);
      tbl[1]  = mk(0,0,1,32'h04,32'h00500093, 1,1,32'h04,32'h00500093,0);
      tbl[2]  = mk(0,0,1,32'h08,32'h00100113, 1,1,32'h08,32'h00100113,0);
      tbl[3]  = mk(0,1,1,32'h0C,32'h002081B3, 1,1,32'h08,32'h00100113,1);
      tbl[4]  = mk(0,1,1,32'h0C,32'h002081B3, 0,1,32'h08,32'h00100113,1);
      tbl[5]  = mk(0,0,1,32'h10,32'h00000033, 0,1,32'h0C,32'h002081B3,0);
      tbl[6]  = mk(0,0,1,32'h10,32'h00000033, 1,1,32'h10,32'h00000033,0);
      tbl[7]  = mk(0,1,1,32'h14,32'h40000033, 1,1,32'h10,32'h00000033,1);
      tbl[8]  = mk(1,0,1,32'h14,32'h40000033, 0,0,32'h00,NOP,0);
      tbl[9]  = mk(0,0,1,32'h18,32'h00400093, 1,1,32'h18,32'h00400093,0);
      tbl[10] = mk(0,1,1,32'h1C,32'h00108093, 1,1,32'h18,32'h00400093,1);
      tbl[11] = mk(1,1,1,32'h1C,32'h00108093, 0,0,32'h00,NOP,0);
      tbl[12] = mk(0,0,0,32'h40,32'h00000000, 1,0,32'h40,NOP,0);
      tbl[13] = mk(0,0,1,32'h44,32'h00A00513, 1,1,32'h44,32'h00A00513,0);

      flush = 0; stall = 0; in_valid = 0; pc_in = 0; instr_in = 0;
      model_reset();
      #12;
      chk("reset_valid", 32'(out_valid), 0);
      chk("reset_pc", pc_out, 0);
      chk("reset_instr", instr_out, NOP);
      chk("reset_skid", 32'(skid_full), 0);
      chk("reset_ready", 32'(in_ready), 1);

      @(negedge clk);
      rst = 1;
      for (int r = 0; r < 14; r++) begin
         drive(tbl[r].f, tbl[r].s, tbl[r].v, tbl[r].pc, tbl[r].ins);
         e = tbl[r].oins;
         chk($sformatf("row%0d_ready", r), 32'(rdy_obs), 32'(tbl[r].rdy));
         chk($sformatf("row%0d_valid", r), 32'(out_valid), 32'(tbl[r].ov));
         chk($sformatf("row%0d_pc", r), pc_out, tbl[r].opc);
         chk($sformatf("row%0d_instr", r), instr_out, tbl[r].oins);
         chk($sformatf("row%0d_skid", r), 32'(skid_full), 32'(tbl[r].sk));
         chk($sformatf("row%0d_opcode", r), 32'(opcode), 32'(e[6:0]));
         chk($sformatf("row%0d_rd", r), 32'(rd), 32'(e[11:7]));
         chk($sformatf("row%0d_funct3", r), 32'(funct3), 32'(e[14:12]));
         chk($sformatf("row%0d_rs1", r), 32'(rs1), 32'(e[19:15]));
         chk($sformatf("row%0d_rs2", r), 32'(rs2), 32'(e[24:20]));
         chk($sformatf("row%0d_funct7", r), 32'(funct7), 32'(e[31:25]));
         chk($sformatf("row%0d_imm", r), 32'(imm), 32'(e[31:7]));
      end

      // Async reset while stalled with a parked instruction.
      drive(0, 0, 1, 32'h48, 32'h00000093);
      drive(0, 1, 1, 32'h4C, 32'h00000113);
      chk("pre_arst_skid", 32'(skid_full), 1);
      chk("pre_arst_pc", pc_out, 32'h48);
      #3;
      rst = 0;
      model_reset();
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_pc", pc_out, 0);
      chk("arst_instr", instr_out, NOP);
      chk("arst_skid", 32'(skid_full), 0);
      chk("arst_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst = 1;
      drive(0, 0, 1, 32'h100, 32'h00500093);
      chk("warm2_valid", 32'(out_valid), 0);
      chk("warm2_instr", instr_out, NOP);
      chk("warm2_pc", pc_out, 32'h100);
      drive(0, 0, 1, 32'h104, 32'h00600113);
      chk("warm2_first_valid", 32'(out_valid), 1);
      chk("warm2_first_instr", instr_out, 32'h00600113);

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic f, s, v;
         f = ($urandom_range(0, 9) == 0);
         s = ($urandom_range(0, 2) == 0);
         v = ($urandom_range(0, 3) != 0);
         drive(f, s, v, $urandom & 32'hFFFF_FFFC, $urandom);
         chk($sformatf("rnd%0d_ready", n), 32'(rdy_obs), 32'(m_rdy));
         chk($sformatf("rnd%0d_valid", n), 32'(out_valid), 32'(m_v));
         chk($sformatf("rnd%0d_pc", n), pc_out, m_pc);
         chk($sformatf("rnd%0d_instr", n), instr_out, m_ins);
         chk($sformatf("rnd%0d_skid", n), 32'(skid_full), 32'(m_skid.size() != 0));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/if_id_stage_skid.md
Name: if_id_stage_skid

Overview:
- Parametrised IF/ID pipeline register for the RISC-V core. Sits between the fetch unit and synchronous instruction memory on one side, and decode on the other.
- Adds to the basic IF/ID register:
  - a valid bit;
  - a one-entry skid buffer, so an instruction returned during a stall is not lost;
  - a configurable reset warm-up window;
  - a ready handshake back to fetch.
- Provides pre-sliced RV32 decode fields.

Parameters:
- XLEN, 32, width of PC.
- ILEN, 32, instruction width. Field slicing assumes 32.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).
- WARMUP, 1, advancing cycles after reset during which instr_in is discarded (memory latency). Range 0..7.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  kill stage contents (branch/jump taken)
- stall  in  1  hold stage contents (load-use hazard)
- in_valid  in  1  pc_in/instr_in carry a fetched instruction
- in_ready  out  1  stage or skid can accept input this cycle
- pc_in  in  XLEN  PC of the fetched instruction
- instr_in  in  ILEN  fetched instruction word
- out_valid  out  1  stage holds a real instruction
- pc_out  out  XLEN  registered PC
- instr_out  out  ILEN  registered instruction
- opcode  out  7  instr_out[6:0]
- funct3  out  3  instr_out[14:12]
- funct7  out  7  instr_out[31:25]
- rs1  out  5  instr_out[19:15]
- rs2  out  5  instr_out[24:20]
- rd  out  5  instr_out[11:7]
- imm  out  25  instr_out[31:7]
- skid_full  out  1  skid entry occupied (debug/perf)

Behaviour:
- Reset (rst=0, async):
  - pc_out=0, instr_out=NOP_INSTR, out_valid=0.
  - Skid empty.
  - warm-up counter=WARMUP.
  - Reset mid-operation discards all state immediately.
- in_ready = !skid_full. This is combinational.
- "Accept" means in_valid & in_ready.
- Per-cycle priority is flush > stall > advance.
- Flush:
  - pc_out=0, instr_out=NOP_INSTR, out_valid=0.
  - Skid cleared.
  - Input ignored.
  - Warm-up counter unchanged.
- Stall (no flush):
  - pc_out, instr_out and out_valid hold.
  - If accept: skid loads {pc_in, instr_in}, so skid_full=1 next cycle.
  - If skid already full: in_ready=0 and upstream must hold.
- Advance (no flush, no stall):
  - If skid_full: stage loads the skid entry with out_valid=1. Skid is cleared. Inputs are not taken that cycle (in_ready=0).
  - Else if accept: stage loads pc_in/instr_in with out_valid=1.
  - Else: stage loads bubble (instr_out=NOP_INSTR, out_valid=0, pc_out=pc_in).
- Warm-up:
  - While the counter is nonzero, each advancing cycle decrements it.
  - During such a cycle the stage loads pc_out=pc_in, instr_out=NOP_INSTR, out_valid=0, and input is discarded regardless of in_valid.
  - Stall and flush cycles do not decrement the counter.
  - Skid capture is suppressed while the counter is nonzero.
- Latency: accepted instruction appears on outputs 1 cycle after an advancing cycle.
- Stall release: a skid-buffered instruction appears 1 cycle after stall deasserts.
- Simultaneous flush+stall: flush wins.
- Simultaneous flush + skid_full: skid dropped.
- Decode fields are pure slices of instr_out. They are valid even when out_valid=0 (bubble decodes as NOP).

Test Plan:
- Reset, WARMUP=1:
  - Release rst; cycle 1 in_valid=1, pc_in=0x0, instr_in=0xDEADBEEF -> pc_out=0, instr_out=0x13, out_valid=0.
  - Cycle 2 pc_in=0x4, instr_in=0x00500093 -> pc_out=0x4, instr_out=0x00500093, rd=1, opcode=0x13, out_valid=1.
- Stall with return:
  - Stage holds pc 0x8. Assert stall 2 cycles while in_valid=1, pc_in=0xC, instr_in=0x002081B3.
  - Outputs hold 0x8; skid_full=1 and in_ready=0 from the second cycle.
  - Drop stall -> next cycle pc_out=0xC, instr_out=0x002081B3. Skid empty one cycle later.
- Flush:
  - skid_full=1, assert flush -> next cycle pc_out=0, instr_out=0x13, out_valid=0, skid_full=0, in_ready=1.
- Flush+stall same cycle -> flush result as above; held instruction lost.
- in_valid=0 while advancing -> out_valid=0, instr_out=0x13, pc_out=pc_in.
- Async reset asserted mid-stall with skid_full=1 -> all outputs at reset values without a clock edge. Warm-up restarts (first post-reset instruction discarded).
